// File: rtl/samp_pkg.sv
// samp_pkg: shared FSM encoding, register map and sync byte for samp_framer
package samp_pkg;
    typedef enum logic [2:0] {IDLE, SETTLE, SYNC, SEQ, LEN, PULL, DATA, CSUM} state_t;
    localparam logic [3:0] REG_CTRL = 4'd0;
    localparam logic [3:0] REG_MAX = 4'd1;
    localparam logic [3:0] REG_SEQ = 4'd2;
    localparam logic [1:0] REG_PKT_HI = 2'b01;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
endpackage

// File: rtl/samp_framer.sv
// samp_framer: packs queued 32-bit samples into sync/seq/len/data/csum byte packets
module samp_framer
    import samp_pkg::*;
#(
    parameter int MAX_SAMPLES = 63,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] samp_stream_data,
    input  logic [7:0]  samp_stream_count,
    input  logic        samp_stream_avail,
    output logic        samp_stream_pull,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [15:0] wb_adr_i,
    input  logic [7:0]  wb_dat_i,
    output logic [7:0]  wb_dat_o,
    output logic        wb_ack_o
);
    state_t state;
    logic enable, settle_cnt;
    logic [1:0] bcnt;
    logic [7:0] max_samples, seq, n, rem, csum;
    logic [31:0] pkt_cnt, sreg;
    logic [3:0] adr;
    logic busy, xfer, wr, unused_adr;
    logic [7:0] n_calc;
    assign adr = wb_adr_i[3:0];
    assign unused_adr = ^wb_adr_i[15:4];
    assign busy = (state != IDLE) && (state != SETTLE);
    assign xfer = tx_valid && tx_ready;
    assign wr = wb_cyc_i && wb_stb_i && wb_we_i;
    assign n_calc = (samp_stream_count < max_samples) ? samp_stream_count : max_samples;
    assign wb_ack_o = 1'b1;
    assign wb_dat_o = (adr == REG_CTRL) ? {6'b0, busy, enable} :
                      (adr == REG_MAX)  ? max_samples :
                      (adr == REG_SEQ)  ? seq :
                      (adr[3:2] == REG_PKT_HI) ? pkt_cnt[{adr[1:0], 3'b000} +: 8] : 8'h00;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            enable <= 1'b0;
            settle_cnt <= 1'b0;
            bcnt <= 2'd0;
            max_samples <= 8'(MAX_SAMPLES);
            seq <= 8'd0;
            n <= 8'd0;
            rem <= 8'd0;
            csum <= 8'd0;
            pkt_cnt <= 32'd0;
            sreg <= 32'd0;
            tx_data <= 8'd0;
            tx_valid <= 1'b0;
            samp_stream_pull <= 1'b0;
        end else begin
            samp_stream_pull <= 1'b0;
            if (wr && adr == REG_CTRL) enable <= wb_dat_i[0];
            if (wr && adr == REG_MAX && !busy) max_samples <= (wb_dat_i == 8'd0) ? 8'd1 : wb_dat_i;
            if (xfer && (state == SEQ || state == LEN || state == DATA)) csum <= csum ^ tx_data;
            case (state)
                IDLE: if (enable) begin
                    state <= SETTLE;
                    settle_cnt <= 1'b0;
                end
                SETTLE: if (!enable) state <= IDLE;
                else if (samp_stream_avail && n_calc != 8'd0) begin
                    settle_cnt <= 1'b1;
                    if (settle_cnt) begin
                        state <= SYNC;
                        n <= n_calc;
                        csum <= 8'd0;
                        tx_data <= SYNC_BYTE;
                        tx_valid <= 1'b1;
                    end
                end else settle_cnt <= 1'b0;
                SYNC: if (xfer) begin
                    state <= SEQ;
                    tx_data <= seq;
                end
                SEQ: if (xfer) begin
                    state <= LEN;
                    tx_data <= n;
                end
                LEN: if (xfer) begin
                    state <= PULL;
                    tx_valid <= 1'b0;
                    rem <= n;
                end
                PULL: if (samp_stream_avail) begin
                    state <= DATA;
                    samp_stream_pull <= 1'b1;
                    sreg <= samp_stream_data;
                    tx_data <= samp_stream_data[7:0];
                    tx_valid <= 1'b1;
                    bcnt <= 2'd0;
                end
                DATA: if (xfer) begin
                    sreg <= sreg >> 8;
                    bcnt <= bcnt + 2'd1;
                    tx_data <= sreg[15:8];
                    if (bcnt == 2'd3) begin
                        rem <= rem - 8'd1;
                        if (rem == 8'd1) begin
                            state <= CSUM;
                            tx_data <= csum ^ tx_data;
                        end else begin
                            state <= PULL;
                            tx_valid <= 1'b0;
                        end
                    end
                end
                CSUM: if (xfer) begin
                    state <= SETTLE;
                    settle_cnt <= 1'b0;
                    tx_valid <= 1'b0;
                    seq <= seq + 8'd1;
                    pkt_cnt <= pkt_cnt + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_samp_framer.sv
// tb_samp_framer: scoreboard bench for samp_framer packets, stalls, gaps and registers
module tb_samp_framer;
    import samp_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    logic [31:0] samp_stream_data;
    logic [7:0] samp_stream_count, tx_data, wb_dat_o;
    logic samp_stream_avail, samp_stream_pull, tx_valid, wb_ack_o;
    logic tx_ready = 1'b1;
    logic wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
    logic [15:0] wb_adr_i = 16'h0;
    logic [7:0] wb_dat_i = 8'h0;

    logic [31:0] mem [0:1023];
    int rd = 0, total = 0, cyc = 0;
    logic gap = 1'b0, rand_ready = 1'b0;
    int tests = 0, fails = 0, pulls = 0, bytes_seen = 0, last_pull = -10;
    logic [7:0] exp_q[$];
    logic [7:0] exp_seq = 8'd0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic [7:0] d, e;
    logic [31:0] v;
    int p0, p1, b0, k;

    assign samp_stream_avail = (rd < total) && !gap;
    assign samp_stream_data = mem[rd];
    assign samp_stream_count = (total - rd > 255) ? 8'd255 : 8'(total - rd);

    samp_framer dut (
        .clk(clk), .rst_n(rst_n),
        .samp_stream_data(samp_stream_data), .samp_stream_count(samp_stream_count),
        .samp_stream_avail(samp_stream_avail), .samp_stream_pull(samp_stream_pull),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (samp_stream_pull) rd <= rd + 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) check("tx_hold", {tx_valid, tx_data}, {1'b1, prev_data});
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) check("extra_byte", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("tx_byte", tx_data, e);
                end
                bytes_seen++;
            end
            if (samp_stream_pull) begin
                pulls++;
                check("pull_gap", 32'(cyc - last_pull >= 3), 1);
                last_pull = cyc;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data = tx_data;
        end else prev_stall = 1'b0;
    end

    initial forever begin
        @(posedge clk);
        #1;
        tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_wr(input logic [3:0] a, input logic [7:0] dat);
        wb_adr_i = {12'h0, a};
        wb_dat_i = dat;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i = 1'b1;
        tick();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i = 1'b0;
    endtask

    task automatic wb_rd(input logic [3:0] a, output logic [7:0] dat);
        wb_adr_i = {12'h0, a};
        #1;
        dat = wb_dat_o;
    endtask

    task automatic rd_pkt(output logic [31:0] cnt);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            wb_rd(4'(4 + i), b);
            cnt[8*i +: 8] = b;
        end
    endtask

    task automatic push_pkt(input int start, input int n);
        logic [7:0] cs, b;
        exp_q.push_back(8'hA5);
        exp_q.push_back(exp_seq);
        exp_q.push_back(8'(n));
        cs = exp_seq ^ 8'(n);
        for (int s = 0; s < n; s++)
            for (int j = 0; j < 4; j++) begin
                b = mem[start + s][8*j +: 8];
                exp_q.push_back(b);
                cs ^= b;
            end
        exp_q.push_back(cs);
        exp_seq++;
    endtask

    task automatic load(input int n, input int npkt);
        for (int i = 0; i < n; i++) mem[total + i] = $urandom;
        push_pkt(total, npkt);
        total += n;
    endtask

    task automatic wait_done();
        int c = 0;
        while (exp_q.size() != 0 && c < 5000) begin
            tick();
            c++;
        end
        check("pkt_done_timeout", exp_q.size(), 0);
        tick(3);
    endtask

    initial begin
        tick(3);
        check("rst_valid", tx_valid, 0);
        check("rst_data", tx_data, 0);
        check("rst_pull", samp_stream_pull, 0);
        rst_n = 1'b1;
        tick();
        wb_rd(REG_CTRL, d); check("rst_ctrl", d, 0);
        wb_rd(REG_MAX, d);  check("rst_max", d, 63);
        wb_rd(REG_SEQ, d);  check("rst_seq", d, 0);
        rd_pkt(v);          check("rst_pktcnt", v, 0);
        tick();
        // two known samples, ready always high
        mem[0] = 32'h11223344;
        mem[1] = 32'hAABBCCDD;
        push_pkt(0, 2);
        total = 2;
        p0 = pulls;
        wb_wr(REG_CTRL, 8'h01);
        wait_done();
        check("pulls_2", pulls - p0, 2);
        wb_rd(REG_SEQ, d); check("seq_after_1", d, exp_seq);
        rd_pkt(v);         check("pktcnt_1", v, 1);
        // random back-pressure
        rand_ready = 1'b1;
        load(5, 5);
        wait_done();
        rand_ready = 1'b0;
        tick();
        // queue runs dry mid-packet
        p0 = pulls;
        load(6, 6);
        k = 0;
        while (pulls - p0 < 2 && k < 500) begin tick(); k++; end
        check("gap_start_timeout", 32'(pulls - p0 >= 2), 1);
        gap = 1'b1;
        p1 = pulls;
        tick(20);
        check("gap_valid", tx_valid, 0);
        check("gap_pull", pulls - p1, 0);
        gap = 1'b0;
        wait_done();
        check("pulls_6", pulls - p0, 6);
        // count above max_samples, enable cleared mid-packet, locked max
        p0 = pulls;
        for (int i = 0; i < 200; i++) mem[total + i] = $urandom;
        push_pkt(total, 63);
        total += 200;
        d = 8'h0;
        k = 0;
        while (!d[1] && k < 200) begin wb_rd(REG_CTRL, d); tick(); k++; end
        check("busy_seen", d[1], 1);
        wb_wr(REG_MAX, 8'd7);
        wb_rd(REG_MAX, d); check("max_locked", d, 63);
        wb_wr(REG_CTRL, 8'h00);
        wait_done();
        check("pulls_63", pulls - p0, 63);
        tick(5);
        wb_rd(REG_CTRL, d); check("idle_after_63", d, 0);
        rd_pkt(v);          check("pktcnt_4", v, 4);
        wb_rd(REG_SEQ, d);  check("seq_4", d, exp_seq);
        total = rd;
        // clear enable after byte 5
        load(3, 3);
        wb_wr(REG_CTRL, 8'h01);
        b0 = bytes_seen;
        k = 0;
        while (bytes_seen < b0 + 5 && k < 500) begin tick(); k++; end
        check("byte5_timeout", 32'(bytes_seen >= b0 + 5), 1);
        wb_wr(REG_CTRL, 8'h00);
        wait_done();
        tick(5);
        wb_rd(REG_CTRL, d); check("idle_after_clear", d, 0);
        // max_samples 0 stored as 1, then small max splits packets
        wb_wr(REG_MAX, 8'd0);
        wb_rd(REG_MAX, d); check("max_zero", d, 1);
        wb_wr(REG_MAX, 8'd2);
        for (int i = 0; i < 5; i++) mem[total + i] = $urandom;
        push_pkt(total, 2);
        push_pkt(total + 2, 2);
        push_pkt(total + 4, 1);
        total += 5;
        wb_wr(REG_CTRL, 8'h01);
        wait_done();
        wb_wr(REG_CTRL, 8'h00);
        tick(5);
        rd_pkt(v); check("pktcnt_8", v, 8);
        wb_wr(REG_MAX, 8'd63);
        // reset mid-packet
        load(4, 4);
        wb_wr(REG_CTRL, 8'h01);
        b0 = bytes_seen;
        k = 0;
        while (bytes_seen < b0 + 3 && k < 500) begin tick(); k++; end
        rst_n = 1'b0;
        tick();
        check("rst_mid_valid", tx_valid, 0);
        check("rst_mid_pull", samp_stream_pull, 0);
        exp_q.delete();
        exp_seq = 8'd0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("rst_mid_silent", tx_valid, 0);
        wb_rd(REG_SEQ, d); check("rst_mid_seq", d, 0);
        wb_rd(REG_CTRL, d); check("rst_mid_ctrl", d, 0);
        rd_pkt(v);          check("rst_mid_pktcnt", v, 0);
        total = rd;
        load(1, 1);
        wb_wr(REG_CTRL, 8'h01);
        wait_done();
        wb_rd(REG_SEQ, d); check("seq_after_rst", d, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/samp_framer.md
SAMP_FRAMER -- requirements
Module: samp_framer

Interface
REQ-001 SHALL have parameter MAX_SAMPLES, default 63: upper bound on samples per packet; legal range 1..255.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5: first byte of every packet.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port samp_stream_data  input  32  sample at the sample queue read pointer.
REQ-006 SHALL have port samp_stream_count  input  8  samples available in the current frame, capped at 255.
REQ-007 SHALL have port samp_stream_avail  input  1  sample queue has a sample.
REQ-008 SHALL have port samp_stream_pull  output  1  consume one sample; single-cycle pulse.
REQ-009 SHALL have ports tx_data  output  8, tx_valid  output  1, tx_ready  input  1: the byte stream toward the host transport.
REQ-010 SHALL have ports wb_stb_i, wb_cyc_i, wb_we_i  input  1; wb_adr_i  input  16; wb_dat_i  input  8; wb_dat_o  output  8; wb_ack_o  output  1: the register bus.

Function
REQ-011 SHALL transfer a tx byte only on a cycle with tx_valid && tx_ready, and SHALL hold tx_data stable while tx_valid && !tx_ready.
REQ-012 SHALL emit each packet as: SYNC_BYTE; seq; N; 4*N sample bytes, least-significant byte first; csum.
REQ-013 SHALL compute csum as the 8-bit XOR of every packet byte after SYNC_BYTE and before csum.
REQ-014 SHALL latch N at packet start as min(samp_stream_count, max_samples) and SHALL NOT start a packet when that value is 0.
REQ-015 SHALL increment seq by 1 modulo 256 after each csum byte is transferred.
REQ-016 SHALL use FSM states IDLE, SETTLE, SYNC, SEQ, LEN, PULL, DATA, CSUM.
REQ-017 IDLE->SETTLE when enable is set; SETTLE->SYNC after 2 consecutive cycles in SETTLE with samp_stream_avail=1 and N!=0; SETTLE->IDLE when enable is clear.
REQ-018 SYNC->SEQ->LEN->PULL SHALL each advance on a byte transfer.
REQ-019 PULL SHALL pulse samp_stream_pull for one cycle when samp_stream_avail=1, capture samp_stream_data into a 32-bit shift register on that cycle, then go to DATA.
REQ-020 DATA SHALL send 4 bytes, then go to PULL if samples remain in the packet, otherwise to CSUM.
REQ-021 samp_stream_pull SHALL be separated from the previous pull by at least 2 cycles, because queue avail/count/data lag one cycle.
REQ-022 If samp_stream_avail=0 in PULL, the FSM SHALL wait in PULL with tx_valid=0; the packet is never truncated.
REQ-023 CSUM SHALL go to SETTLE on transfer; SETTLE then re-evaluates the enable bit.
REQ-024 Clearing enable mid-packet SHALL let the current packet complete; the FSM SHALL then return to IDLE.
REQ-025 Register 0 SHALL read {busy, enable} in bits [1:0], where busy = FSM not IDLE/SETTLE; a write to register 0 SHALL set enable from wb_dat_i[0].
REQ-026 Register 1 SHALL hold max_samples; writes SHALL be ignored while busy; a written value of 0 SHALL be stored as 1.
REQ-027 Registers 4..7 SHALL read a 32-bit packet counter (LSB first); it increments per completed packet and wraps.
REQ-028 Register 2 SHALL read seq; other addresses SHALL read 0; decode uses wb_adr_i[3:0]; a register write requires wb_cyc_i && wb_stb_i && wb_we_i.
REQ-029 wb_dat_o SHALL be combinational from the address; wb_ack_o SHALL be constant 1.

Reset
REQ-030 While rst_n=0 at a clock edge: FSM=IDLE, tx_valid=0, tx_data=0, samp_stream_pull=0, enable=0, seq=0, max_samples=MAX_SAMPLES, packet counter=0, csum=0.
REQ-031 Reset mid-packet SHALL abort the packet with no further bytes; the next packet SHALL start with seq=0.

Structure
REQ-032 FSM state encodings, register addresses and SYNC_BYTE default SHALL live in a shared package samp_pkg.
REQ-033 Byte emission, including the shift register and csum accumulator, MAY be a sub-module samp_byte_tx; the FSM and register file SHALL stay in samp_framer.

Verification
REQ-034 Enable, count=2, samples 0x11223344 and 0xAABBCCDD, tx_ready=1 -> bytes A5 00 02 44 33 22 11 DD CC BB AA and csum = XOR of bytes 1..10; exactly 2 pull pulses.
REQ-035 count=200, max_samples=63 -> N=63, 63 pulls; next packet has seq=01 and the packet counter reads 1.
REQ-036 Toggle tx_ready randomly -> tx_data stable while stalled; byte sequence identical to the unstalled run.
REQ-037 Drop avail mid-packet for 20 cycles -> no pull and tx_valid=0 during the gap; the packet resumes intact.
REQ-038 Clear enable after byte 5 -> the packet completes, then IDLE; a register 1 write while busy is ignored; rst_n=0 mid-packet -> tx_valid=0 next cycle.
